// File: rtl/mure_pkg.sv
// Shared widths, FIFO entry layout and sequencer state encoding for the retire sequencer.
package mure_pkg;
  localparam int XLEN      = 32;
  localparam int INST_LEN  = 32;
  localparam int CAUSE_LEN = 8;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic                 compressed;
    logic                 iretired;
    logic                 exception;
    logic                 interrupt;
    logic                 eret;
    logic                 resync;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } mure_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    ARM  = 2'd2
  } seq_state_e;
endpackage

// File: rtl/mure_mw_fifo.sv
// Multi-write / single-read FIFO of retire entries; writes are pre-compacted into ports 0..wr_cnt-1.
module mure_mw_fifo
  import mure_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [$clog2(DEPTH):0] wr_cnt,
  input  mure_entry_t            wr_data [NRET],
  input  logic                   rd_en,
  output mure_entry_t            rd_data,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  mure_entry_t      mem [DEPTH];

  // wr_cnt never exceeds NRET <= DEPTH/2, so its low bits are the pointer step
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_cnt[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
      level  <= level + wr_cnt - LVL_W'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++) begin
      if (LVL_W'(i) < wr_cnt) mem[wr_ptr + PTR_W'(i)] <= wr_data[i];
    end
  end

  // Storage is not reset, so an empty FIFO presents zeros instead of stale entries
  assign rd_data = (level != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/mure_retire_sequencer.sv
// Compacts multi-slot retire/trap events into a FIFO for the trace encoder, with overflow drop and resync.
module mure_retire_sequencer
  import mure_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NRET-1:0]          valids_i,
  input  logic [NRET*XLEN-1:0]     pc_i,
  input  logic [NRET*INST_LEN-1:0] inst_i,
  input  logic [NRET-1:0]          compressed_i,
  input  logic                     exception_i,
  input  logic                     interrupt_i,
  input  logic                     eret_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic                     ready_i,
  input  logic                     clr_ovf_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [INST_LEN-1:0]      inst_data_o,
  output logic                     compressed_o,
  output logic                     iretired_o,
  output logic                     exception_o,
  output logic                     interrupt_o,
  output logic                     eret_o,
  output logic                     resync_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);
  // state | meaning
  // RUN   | normal operation, accept whole cycles that fit
  // DROP  | overflowed, discard all input until FIFO empties
  // ARM   | FIFO drained, first accepted entry carries resync
  localparam int LVL_W = $clog2(DEPTH) + 1;

  seq_state_e       state_q, state_d;
  mure_entry_t      wr_data [NRET];
  mure_entry_t      head;
  logic [LVL_W-1:0] level, k, free, wr_cnt;
  logic             pop, fits, accept, reject, mark_resync;
  int               slot_cnt;

  assign valid_o = (level != '0);
  assign pop     = valid_o & ready_i;
  assign free    = LVL_W'(DEPTH) - level + LVL_W'(pop);
  assign fits    = (free >= k);

  // Slot s lands at write port j when j valid slots precede it
  always_comb begin
    wr_data  = '{default: '0};
    slot_cnt = 0;
    for (int s = 0; s < NRET; s++) begin
      if (valids_i[s]) begin
        for (int j = 0; j < NRET; j++) begin
          if (j == slot_cnt) begin
            wr_data[j].pc         = pc_i[s*XLEN +: XLEN];
            wr_data[j].inst       = inst_i[s*INST_LEN +: INST_LEN];
            wr_data[j].compressed = compressed_i[s];
            wr_data[j].iretired   = 1'b1;
          end
        end
        slot_cnt = slot_cnt + 1;
      end
    end
    if (slot_cnt == 0 && exception_i) begin
      wr_data[0].pc = pc_i[XLEN-1:0];
      slot_cnt      = 1;
    end
    for (int j = 0; j < NRET; j++) begin
      if (j == slot_cnt - 1) begin
        wr_data[j].exception = exception_i;
        wr_data[j].interrupt = exception_i & interrupt_i;
        wr_data[j].eret      = eret_i;
        wr_data[j].cause     = exception_i ? cause_i : '0;
        wr_data[j].tval      = exception_i ? tval_i : '0;
      end
    end
    wr_data[0].resync = mark_resync;
    k = LVL_W'(slot_cnt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (k != '0 && !fits) state_d = DROP;
      DROP: if (level == '0) state_d = ARM;
      ARM:  if (k != '0) state_d = fits ? RUN : DROP;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    reject      = 1'b0;
    mark_resync = 1'b0;
    unique case (state_q)
      RUN: begin
        accept = (k != '0) && fits;
        reject = (k != '0) && !fits;
      end
      ARM: begin
        accept      = (k != '0) && fits;
        reject      = (k != '0) && !fits;
        mark_resync = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_cnt = accept ? k : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          overflow_o <= 1'b0;
    else if (reject)    overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end

  mure_mw_fifo #(.NRET(NRET), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level)
  );

  assign pc_o         = head.pc;
  assign inst_data_o  = head.inst;
  assign compressed_o = head.compressed;
  assign iretired_o   = head.iretired;
  assign exception_o  = head.exception;
  assign interrupt_o  = head.interrupt;
  assign eret_o       = head.eret;
  assign resync_o     = head.resync;
  assign cause_o      = head.cause;
  assign tval_o       = head.tval;
  assign level_o      = level;
endmodule

// File: tb/tb_mure_retire_sequencer.sv
// Directed stimulus with a queue scoreboard; a forked monitor checks every handshaked head entry.
module tb_mure_retire_sequencer;
  import mure_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [1:0]          valids_i;
  logic [2*XLEN-1:0]   pc_i;
  logic [2*INST_LEN-1:0] inst_i;
  logic [1:0]          compressed_i;
  logic                exception_i, interrupt_i, eret_i, ready_i, clr_ovf_i;
  logic [CAUSE_LEN-1:0] cause_i;
  logic [XLEN-1:0]     tval_i;
  logic                valid_o, compressed_o, iretired_o, exception_o, interrupt_o;
  logic                eret_o, resync_o, overflow_o;
  logic [XLEN-1:0]     pc_o, tval_o;
  logic [INST_LEN-1:0] inst_data_o;
  logic [CAUSE_LEN-1:0] cause_o;
  logic [3:0]          level_o;

  int checks   = 0;
  int failures = 0;
  mure_entry_t exp_q[$];

  mure_retire_sequencer #(.NRET(2), .DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valids_i(valids_i), .pc_i(pc_i), .inst_i(inst_i),
    .compressed_i(compressed_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
    .eret_i(eret_i), .cause_i(cause_i), .tval_i(tval_i), .ready_i(ready_i),
    .clr_ovf_i(clr_ovf_i), .valid_o(valid_o), .pc_o(pc_o), .inst_data_o(inst_data_o),
    .compressed_o(compressed_o), .iretired_o(iretired_o), .exception_o(exception_o),
    .interrupt_o(interrupt_o), .eret_o(eret_o), .resync_o(resync_o), .cause_o(cause_o),
    .tval_o(tval_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic mure_entry_t ent(input logic [31:0] p, input logic cmp, iret, e, it, er, rs,
                                      input logic [7:0] c, input logic [31:0] tv);
    ent.pc         = p;
    ent.inst       = iret ? (p ^ 32'h13) : '0;
    ent.compressed = cmp;
    ent.iretired   = iret;
    ent.exception  = e;
    ent.interrupt  = it;
    ent.eret       = er;
    ent.resync     = rs;
    ent.cause      = c;
    ent.tval       = tv;
  endfunction

  task automatic set_in(input logic [1:0] v, input logic [31:0] p0, p1, input logic [1:0] cmp,
                        input logic e, it, er, input logic [7:0] c, input logic [31:0] tv);
    valids_i     = v;
    pc_i         = {p1, p0};
    inst_i       = {p1 ^ 32'h13, p0 ^ 32'h13};
    compressed_i = cmp;
    exception_i  = e;
    interrupt_i  = it;
    eret_i       = er;
    cause_i      = c;
    tval_i       = tv;
  endtask

  task automatic idle();
    set_in(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int n = 0; n < budget && valid_o; n++) cyc();
    chk(name, 64'(valid_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; ready_i = 1'b1; clr_ovf_i = 1'b0;
    idle();

    fork
      forever begin
        @(negedge clk_i);
        if (!rst_i && valid_o && ready_i) begin
          mure_entry_t got, exp;
          got = '{pc_o, inst_data_o, compressed_o, iretired_o, exception_o, interrupt_o,
                  eret_o, resync_o, cause_o, tval_o};
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_entry got=%h exp=none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              failures++;
              $display("FAIL entry got=%h exp=%h", got, exp);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_level", 64'(level_o), 0);
    chk("rst_ovf", 64'(overflow_o), 0);
    chk("rst_pc", 64'(pc_o), 0);
    rst_i = 1'b0;
    cyc();

    // 1: two slots, second compressed, drain in order
    set_in(2'b11, 32'h100, 32'h104, 2'b10, 0, 0, 0, 0, 0);
    chk("no_bypass", 64'(valid_o), 0);
    exp_q.push_back(ent(32'h100, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ent(32'h104, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc(); idle();
    chk("t1_pc0", 64'(pc_o), 64'h100);
    chk("t1_level", 64'(level_o), 2);
    cyc();
    chk("t1_pc1", 64'(pc_o), 64'h104);
    cyc();
    chk("t1_empty", 64'(valid_o), 0);

    // 2: compaction of slot1, then exception on a single slot, then eret on highest slot
    set_in(2'b10, 32'h0, 32'h200, 2'b00, 0, 0, 0, 0, 0);
    exp_q.push_back(ent(32'h200, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc();
    set_in(2'b01, 32'h300, 32'h0, 2'b00, 1, 0, 0, 8'd2, 32'hDEAD);
    exp_q.push_back(ent(32'h300, 0, 1, 1, 0, 0, 0, 8'd2, 32'hDEAD));
    cyc();
    set_in(2'b11, 32'h400, 32'h404, 2'b00, 0, 0, 1, 0, 0);
    exp_q.push_back(ent(32'h400, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ent(32'h404, 0, 1, 0, 0, 1, 0, 0, 0));
    cyc();
    set_in(2'b11, 32'h410, 32'h414, 2'b00, 1, 0, 0, 8'd5, 32'h77);
    exp_q.push_back(ent(32'h410, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ent(32'h414, 0, 1, 1, 0, 0, 0, 8'd5, 32'h77));
    cyc(); idle();
    wait_empty("t2_drain", 20);

    // 3: trap-only interrupt entry
    set_in(2'b00, 32'h500, 32'h0, 2'b00, 1, 1, 0, 8'd7, 32'h55);
    exp_q.push_back(ent(32'h500, 0, 0, 1, 1, 0, 0, 8'd7, 32'h55));
    cyc(); idle();
    chk("t3_iret", 64'(iretired_o), 0);
    chk("t3_inst", 64'(inst_data_o), 0);
    cyc();
    wait_empty("t3_drain", 5);

    // 4: overflow, drop, drain, resync on first entry after drain
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(2'b11, 32'h600 + 32'(i*8), 32'h604 + 32'(i*8), 2'b00, 0, 0, 0, 0, 0);
      if (i < 4) begin
        exp_q.push_back(ent(32'h600 + 32'(i*8), 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ent(32'h604 + 32'(i*8), 0, 1, 0, 0, 0, 0, 0, 0));
      end
      cyc();
      if (i == 3) begin
        chk("t4_full_level", 64'(level_o), 8);
        chk("t4_no_ovf_yet", 64'(overflow_o), 0);
      end
    end
    chk("t4_level", 64'(level_o), 8);
    chk("t4_ovf", 64'(overflow_o), 1);
    ready_i = 1'b1;
    set_in(2'b11, 32'h6F0, 32'h6F4, 2'b00, 0, 0, 0, 0, 0);
    cyc(); idle();
    chk("t4_drop_level", 64'(level_o), 7);
    wait_empty("t4_drain", 20);
    chk("t4_ovf_sticky", 64'(overflow_o), 1);
    cyc();
    set_in(2'b11, 32'h700, 32'h704, 2'b00, 0, 0, 0, 0, 0);
    exp_q.push_back(ent(32'h700, 0, 1, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(ent(32'h704, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc();
    chk("t4_resync", 64'(resync_o), 1);
    set_in(2'b01, 32'h800, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    exp_q.push_back(ent(32'h800, 0, 1, 0, 0, 0, 0, 0, 0));
    clr_ovf_i = 1'b1;
    cyc(); idle();
    clr_ovf_i = 1'b0;
    chk("t4_ovf_clr", 64'(overflow_o), 0);
    wait_empty("t4_drain2", 10);

    // 5: full FIFO, pop and single push in the same cycle
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(2'b11, 32'h900 + 32'(i*8), 32'h904 + 32'(i*8), 2'b00, 0, 0, 0, 0, 0);
      exp_q.push_back(ent(32'h900 + 32'(i*8), 0, 1, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(ent(32'h904 + 32'(i*8), 0, 1, 0, 0, 0, 0, 0, 0));
      cyc();
    end
    chk("t5_full", 64'(level_o), 8);
    chk("t5_stall_pc", 64'(pc_o), 64'h900);
    ready_i = 1'b1;
    set_in(2'b01, 32'hA00, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    exp_q.push_back(ent(32'hA00, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); idle();
    chk("t5_level", 64'(level_o), 8);
    chk("t5_ovf", 64'(overflow_o), 0);
    wait_empty("t5_drain", 20);

    // 6: asynchronous reset with 5 entries stalled
    ready_i = 1'b0;
    set_in(2'b11, 32'hB00, 32'hB04, 2'b00, 0, 0, 0, 0, 0); cyc();
    set_in(2'b11, 32'hB08, 32'hB0C, 2'b00, 0, 0, 0, 0, 0); cyc();
    set_in(2'b01, 32'hB10, 32'h0, 2'b00, 0, 0, 0, 0, 0);   cyc();
    idle();
    chk("t6_level5", 64'(level_o), 5);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_valid", 64'(valid_o), 0);
    chk("t6_level", 64'(level_o), 0);
    chk("t6_ovf", 64'(overflow_o), 0);
    #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    cyc();
    set_in(2'b01, 32'hC00, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    exp_q.push_back(ent(32'hC00, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(); idle();
    chk("t6_after_pc", 64'(pc_o), 64'hC00);
    cyc();
    wait_empty("t6_drain", 5);
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
